pss_peak_detector: RTL and testbench

Peak detector that sits directly downstream of the PSS correlator and consumes its unsigned correlation-magnitude stream. It keeps a moving sum of recent magnitudes and flags a sample exceeding a scaled average as a candidate. It then tracks the local maximum over a short window and emits one detection pulse carrying the peak value and sample index, followed by a hold-off period. Its output drives SSB timing acquisition.

---
 rtl/pss_peak_detector.sv | 164 ++++++++++++++++
 tb/tb_pss_peak_detector.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pss_peak_detector.sv
// Peak detector for the PSS correlator magnitude stream: moving-sum threshold,
// short local-maximum search, one detection pulse per peak, then a hold-off window.
module pss_peak_detector #(
   parameter int IN_DW           = 24,
   parameter int WINDOW_LEN      = 8,
   parameter int DETECTION_SHIFT = 3,
   parameter int MIN_LEVEL       = 1000,
   parameter int TRACK_LEN       = 4,
   parameter int HOLDOFF_LEN     = 16,
   parameter int CNT_DW          = 16
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   // tvalid qualifies tdata; there is no tready, so every valid sample is accepted.
   input  logic [IN_DW-1:0]  s_axis_in_tdata,
   input  logic              s_axis_in_tvalid,
   output logic              peak_detected_o,
   output logic [IN_DW-1:0]  peak_value_o,
   output logic [CNT_DW-1:0] peak_pos_o,
   output logic [2:0]        state_dbg_o
);

   localparam int LOG2_W  = $clog2(WINDOW_LEN);
   localparam int SUM_DW  = IN_DW + LOG2_W;
   localparam int CMP_DW  = SUM_DW + DETECTION_SHIFT;
   localparam int PH_MAX0 = (WINDOW_LEN > TRACK_LEN) ? WINDOW_LEN : TRACK_LEN;
   localparam int PH_MAX  = (PH_MAX0 > HOLDOFF_LEN) ? PH_MAX0 : HOLDOFF_LEN;
   localparam int PH_DW   = $clog2(PH_MAX + 1);

   localparam logic [PH_DW-1:0] FILL_LAST = PH_DW'(WINDOW_LEN - 1);
   localparam logic [PH_DW-1:0] TRK_LAST  = PH_DW'((TRACK_LEN > 0) ? TRACK_LEN - 1 : 0);
   localparam logic [PH_DW-1:0] HOLD_LAST = PH_DW'((HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0);

   typedef enum logic [2:0] {
      ST_FILL    = 3'd0,
      ST_SEARCH  = 3'd1,
      ST_TRACK   = 3'd2,
      ST_REPORT  = 3'd3,
      ST_HOLDOFF = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [PH_DW-1:0]    phase_q, phase_d;
   logic [IN_DW-1:0]    best_q, best_d;
   logic [CNT_DW-1:0]   best_pos_q, best_pos_d;

   logic [IN_DW-1:0]    hist_q [WINDOW_LEN];
   logic [SUM_DW-1:0]   sum_q;
   logic [CNT_DW-1:0]   cnt_q;

   logic [CMP_DW-1:0]   x_scaled;
   logic [CMP_DW-1:0]   sum_scaled;
   logic                candidate;

   // sum_q covers the WINDOW_LEN samples before the current one, so x is excluded.
   assign x_scaled   = CMP_DW'(s_axis_in_tdata) << LOG2_W;
   assign sum_scaled = CMP_DW'(sum_q) << DETECTION_SHIFT;
   assign candidate  = (s_axis_in_tdata > IN_DW'(MIN_LEVEL)) && (x_scaled > sum_scaled);

   assign state_dbg_o = state_q;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      best_d     = best_q;
      best_pos_d = best_pos_q;
      case (state_q)
         ST_FILL: begin
            if (s_axis_in_tvalid) begin
               if (phase_q == FILL_LAST) begin
                  state_d = ST_SEARCH;
                  phase_d = '0;
               end else begin
                  phase_d = phase_q + PH_DW'(1);
               end
            end
         end
         ST_SEARCH: begin
            if (s_axis_in_tvalid && candidate) begin
               best_d     = s_axis_in_tdata;
               best_pos_d = cnt_q;
               phase_d    = '0;
               state_d    = (TRACK_LEN == 0) ? ST_REPORT : ST_TRACK;
            end
         end
         ST_TRACK: begin
            if (s_axis_in_tvalid) begin
               // Strict compare: on a tie the earlier sample stays the peak.
               if (s_axis_in_tdata > best_q) begin
                  best_d     = s_axis_in_tdata;
                  best_pos_d = cnt_q;
               end
               if (phase_q == TRK_LAST) begin
                  state_d = ST_REPORT;
                  phase_d = '0;
               end else begin
                  phase_d = phase_q + PH_DW'(1);
               end
            end
         end
         ST_REPORT: begin
            phase_d = '0;
            state_d = (HOLDOFF_LEN == 0) ? ST_SEARCH : ST_HOLDOFF;
         end
         ST_HOLDOFF: begin
            if (s_axis_in_tvalid) begin
               if (phase_q == HOLD_LAST) begin
                  state_d = ST_SEARCH;
                  phase_d = '0;
               end else begin
                  phase_d = phase_q + PH_DW'(1);
               end
            end
         end
         default: begin
            state_d = ST_FILL;
            phase_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q    <= ST_FILL;
         phase_q    <= '0;
         best_q     <= '0;
         best_pos_q <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         best_q     <= best_d;
         best_pos_q <= best_pos_d;
      end
   end

   // History, running sum and sample index advance in every state, REPORT included.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         for (int i = 0; i < WINDOW_LEN; i++) hist_q[i] <= '0;
         sum_q <= '0;
         cnt_q <= '0;
      end else if (s_axis_in_tvalid) begin
         hist_q[0] <= s_axis_in_tdata;
         for (int i = 1; i < WINDOW_LEN; i++) hist_q[i] <= hist_q[i-1];
         sum_q <= sum_q + SUM_DW'(s_axis_in_tdata) - SUM_DW'(hist_q[WINDOW_LEN-1]);
         cnt_q <= cnt_q + CNT_DW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         peak_detected_o <= 1'b0;
         peak_value_o    <= '0;
         peak_pos_o      <= '0;
      end else begin
         peak_detected_o <= (state_q == ST_REPORT);
         if (state_q == ST_REPORT) begin
            peak_value_o <= best_q;
            peak_pos_o   <= best_pos_q;
         end
      end
   end

endmodule

// File: tb/tb_pss_peak_detector.sv
// Bench for pss_peak_detector: directed test-plan scenarios plus random traffic,
// all checked cycle by cycle against a sample-index based reference model.
module tb_pss_peak_detector;

   localparam int IN_DW           = 24;
   localparam int WINDOW_LEN      = 8;
   localparam int DETECTION_SHIFT = 3;
   localparam int MIN_LEVEL       = 1000;
   localparam int TRACK_LEN       = 4;
   localparam int HOLDOFF_LEN     = 16;
   localparam int CNT_DW          = 16;
   localparam int EW              = 1 + IN_DW + CNT_DW;

   // ---------------- clock / reset / DUT ----------------
   logic              clk_i = 1'b0;
   logic              reset_ni = 1'b0;
   logic [IN_DW-1:0]  s_axis_in_tdata = '0;
   logic              s_axis_in_tvalid = 1'b0;
   logic              peak_detected_o;
   logic [IN_DW-1:0]  peak_value_o;
   logic [CNT_DW-1:0] peak_pos_o;
   logic [2:0]        state_dbg_o;

   always #5 clk_i = ~clk_i;

   pss_peak_detector #(
      .IN_DW(IN_DW), .WINDOW_LEN(WINDOW_LEN), .DETECTION_SHIFT(DETECTION_SHIFT),
      .MIN_LEVEL(MIN_LEVEL), .TRACK_LEN(TRACK_LEN), .HOLDOFF_LEN(HOLDOFF_LEN),
      .CNT_DW(CNT_DW)
   ) dut (
      .clk_i(clk_i),
      .reset_ni(reset_ni),
      .s_axis_in_tdata(s_axis_in_tdata),
      .s_axis_in_tvalid(s_axis_in_tvalid),
      .peak_detected_o(peak_detected_o),
      .peak_value_o(peak_value_o),
      .peak_pos_o(peak_pos_o),
      .state_dbg_o(state_dbg_o)
   );

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pulse_cnt = 0;
   int pulse_cyc = 0;
   int last_drive_edge = 0;
   int accept_cyc = 0;
   logic [IN_DW-1:0]  last_val = '0;
   logic [CNT_DW-1:0] last_pos = '0;
   logic [EW-1:0] exp_q[$];
   logic [IN_DW-1:0] stim[$];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   // ---------------- reference model (works on sample indices) ----------------
   longint samp[$];
   bit     m_track = 0;
   bit     m_report = 0;
   int     m_end = 0;
   int     m_search_from = WINDOW_LEN;
   longint m_best = 0;
   int     m_best_p = 0;
   logic   m_det = 1'b0;
   logic [IN_DW-1:0]  m_val = '0;
   logic [CNT_DW-1:0] m_pos = '0;

   function automatic bit is_candidate(input int k, input longint x);
      longint s = 0;
      for (int i = k - WINDOW_LEN; i < k; i++) s += samp[i];
      return (x > MIN_LEVEL) && (x * WINDOW_LEN > s * (longint'(1) << DETECTION_SHIFT));
   endfunction

   // Outputs expected right after a clock edge with these inputs applied.
   task automatic model_step(input logic rst_n, input logic v, input logic [IN_DW-1:0] d);
      int k;
      if (!rst_n) begin
         samp.delete();
         m_track = 0; m_report = 0; m_search_from = WINDOW_LEN;
         m_det = 1'b0; m_val = '0; m_pos = '0;
      end else begin
         m_det = 1'b0;
         if (m_report) begin
            m_det = 1'b1;
            m_val = IN_DW'(m_best);
            m_pos = CNT_DW'(m_best_p);
            m_report = 0;
            if (v) samp.push_back(longint'(d));
            m_search_from = samp.size() + HOLDOFF_LEN;
         end else if (v) begin
            k = samp.size();
            if (m_track) begin
               if (longint'(d) > m_best) begin m_best = d; m_best_p = k; end
               if (k == m_end) begin m_track = 0; m_report = 1; end
            end else if (k >= m_search_from && is_candidate(k, longint'(d))) begin
               m_best = d; m_best_p = k;
               if (TRACK_LEN == 0) m_report = 1;
               else begin m_track = 1; m_end = k + TRACK_LEN; end
            end
            samp.push_back(longint'(d));
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic rst_n, input logic v, input logic [IN_DW-1:0] d);
      @(negedge clk_i);
      reset_ni = rst_n;
      s_axis_in_tvalid = v;
      s_axis_in_tdata = d;
      last_drive_edge = cyc + 1;
      model_step(rst_n, v, d);
      exp_q.push_back({m_det, m_val, m_pos});
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) drive(1'b0, 1'($urandom_range(0, 1)), IN_DW'($urandom));
      @(negedge clk_i);
      pulse_cnt = 0;
      reset_ni = 1'b1;
      s_axis_in_tvalid = 1'b0;
   endtask

   task automatic build(input int base, input int len);
      stim.delete();
      for (int i = 0; i < len; i++) stim.push_back(IN_DW'(base));
   endtask

   task automatic play(input int first, input int last, input bit gaps, input int lat_idx);
      for (int i = first; i <= last; i++) begin
         if (gaps) drive(1'b1, 1'b0, IN_DW'($urandom));
         drive(1'b1, 1'b1, stim[i]);
         if (i == lat_idx) accept_cyc = last_drive_edge;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0);
   endtask

   // ---------------- scoreboard / compare process ----------------
   always @(posedge clk_i) begin
      logic [EW-1:0] e;
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({peak_detected_o, peak_value_o, peak_pos_o} !== e) begin
            failures++;
            $display("FAIL cycle_out cyc=%0d got det=%0b val=%0d pos=%0d exp det=%0b val=%0d pos=%0d",
                     cyc, peak_detected_o, peak_value_o, peak_pos_o,
                     e[EW-1], e[EW-2 -: IN_DW], e[CNT_DW-1:0]);
         end
      end
      if (peak_detected_o === 1'b1) begin
         pulse_cnt++;
         pulse_cyc = cyc;
         last_val = peak_value_o;
         last_pos = peak_pos_o;
      end
   end

   // ---------------- scenarios ----------------
   initial begin
      // Reset with random data, then zero input: nothing may fire.
      do_reset();
      check("reset_det", longint'(peak_detected_o), 0);
      check("reset_val", longint'(peak_value_o), 0);
      check("reset_pos", longint'(peak_pos_o), 0);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, '0);
      idle(2);
      check("reset_no_pulse", pulse_cnt, 0);

      // Single spike; pulse follows the index-20 edge by TRACK_LEN+1 edges.
      do_reset();
      build(100, 40); stim[20] = 10000;
      play(0, 39, 1'b0, 20); idle(3);
      check("spike_count", pulse_cnt, 1);
      check("spike_val", longint'(last_val), 10000);
      check("spike_pos", longint'(last_pos), 20);
      check("spike_latency", pulse_cyc - accept_cyc, TRACK_LEN + 1);

      // Local maximum inside the track window.
      do_reset();
      build(100, 40); stim[20] = 5000; stim[21] = 9000; stim[22] = 7000;
      play(0, 39, 1'b0, -1); idle(3);
      check("lmax_count", pulse_cnt, 1);
      check("lmax_val", longint'(last_val), 9000);
      check("lmax_pos", longint'(last_pos), 21);

      do_reset();
      build(100, 40); stim[20] = 5000; stim[21] = 9000; stim[22] = 9000;
      play(0, 39, 1'b0, -1); idle(3);
      check("tie_val", longint'(last_val), 9000);
      check("tie_pos", longint'(last_pos), 21);

      // Gating: spike during fill, below floor, below scaled average.
      do_reset();
      build(100, 40); stim[3] = 10000;
      play(0, 39, 1'b0, -1); idle(3);
      check("gate_fill", pulse_cnt, 0);
      do_reset();
      build(0, 40); stim[20] = 500;
      play(0, 39, 1'b0, -1); idle(3);
      check("gate_floor", pulse_cnt, 0);
      do_reset();
      build(1000, 40); stim[20] = 7000;
      play(0, 39, 1'b0, -1); idle(3);
      check("gate_avg", pulse_cnt, 0);

      // Hold-off suppresses a second spike at 30 but not at 60.
      do_reset();
      build(100, 50); stim[20] = 10000; stim[30] = 10000;
      play(0, 49, 1'b0, -1); idle(3);
      check("hold_count", pulse_cnt, 1);
      check("hold_pos", longint'(last_pos), 20);
      do_reset();
      build(100, 80); stim[20] = 10000; stim[60] = 10000;
      play(0, 39, 1'b0, -1);
      check("hold2_first_pos", longint'(last_pos), 20);
      play(40, 79, 1'b0, -1); idle(3);
      check("hold2_count", pulse_cnt, 2);
      check("hold2_second_pos", longint'(last_pos), 60);

      // Valid toggling: identical result, idle cycles do not advance anything.
      do_reset();
      build(100, 40); stim[20] = 10000;
      play(0, 39, 1'b1, -1); idle(3);
      check("gaps_count", pulse_cnt, 1);
      check("gaps_val", longint'(last_val), 10000);
      check("gaps_pos", longint'(last_pos), 20);

      // Reset in the middle of tracking discards the candidate.
      do_reset();
      build(100, 40); stim[20] = 10000;
      play(0, 22, 1'b0, -1);
      do_reset();
      idle(6);
      check("rst_track_no_pulse", pulse_cnt, 0);
      play(0, 39, 1'b0, -1); idle(3);
      check("rst_track_count", pulse_cnt, 1);
      check("rst_track_pos", longint'(last_pos), 20);

      // Random traffic: gaps, spikes, plateaus and occasional resets.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         int r;
         logic [IN_DW-1:0] d;
         r = $urandom_range(0, 999);
         if (r < 40)      d = IN_DW'($urandom_range(1000, 30000));
         else if (r < 60) d = IN_DW'($urandom_range(800, 1200));
         else             d = IN_DW'($urandom_range(0, 200));
         if ($urandom_range(0, 499) == 0) drive(1'b0, 1'b1, d);
         else drive(1'b1, 1'($urandom_range(0, 3) != 0), d);
      end
      idle(4);

      @(negedge clk_i);
      @(negedge clk_i);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
